// File: rtl/calc_uart_sequencer.sv
// Keystroke parser and sequencer between UART RX, the calculator datapath and the 7-seg driver.
// Optional idle-entry timeout is compiled in when TIMEOUT_EN is defined.
module calc_uart_sequencer #(
  parameter int NDIG           = 2,
  parameter int TIMEOUT_CYCLES = 100_000_000,
  parameter int NBITS_TIMEOUT  = 27
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  output logic [6:0]  op_a,
  output logic [6:0]  op_b,
  output logic [1:0]  op_code,
  output logic        calc_start,
  input  logic        calc_done,
  input  logic [14:0] calc_result,
  output logic [4:0]  disp0,
  output logic [4:0]  disp1,
  output logic [4:0]  disp2,
  output logic [4:0]  disp3
);

  typedef enum logic [2:0] {IDLE, OPA, OPB, EXEC, WAIT, CONV, SHOW, ERR} state_t;

  localparam logic [4:0] BLANK  = 5'h10;
  localparam logic [4:0] MINUS  = 5'h11;
  localparam logic [4:0] ELET   = 5'h12;
  localparam logic [3:0] NDIG_C = 4'(NDIG);

  state_t           state;
  logic [3:0]       cnt_a, cnt_b;
  logic [14:0]      mag;
  logic             neg, range_err;
  logic [3:0][3:0]  bcd;
  logic [1:0]       k;

  logic       is_dig, is_op, is_eq, is_clr;
  logic [1:0] opc;
  logic [6:0] dval;
  logic       do_clear, tmo_hit, abort;

  always_comb begin
    is_dig = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    is_op  = (rx_data == 8'h2B) || (rx_data == 8'h2D) || (rx_data == 8'h2A);
    is_eq  = (rx_data == 8'h3D) || (rx_data == 8'h0D);
    is_clr = (rx_data == 8'h43) || (rx_data == 8'h63);
    dval   = {3'b000, rx_data[3:0]};
    opc    = 2'd0;
    if (rx_data == 8'h2D) opc = 2'd1;
    else if (rx_data == 8'h2A) opc = 2'd2;
    do_clear = rx_done && is_clr &&
               (state != EXEC) && (state != WAIT) && (state != CONV);
  end

`ifdef TIMEOUT_EN
  localparam logic [NBITS_TIMEOUT-1:0] TMO_LAST = NBITS_TIMEOUT'(TIMEOUT_CYCLES - 1);
  logic [NBITS_TIMEOUT-1:0] tmo_cnt;

  // Counts idle cycles while an operand is being typed; any byte restarts it.
  always_ff @(posedge clk) begin
    if (rst || rx_done || ((state != OPA) && (state != OPB)) || tmo_hit)
      tmo_cnt <= '0;
    else
      tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign tmo_hit = ((state == OPA) || (state == OPB)) && !rx_done && (tmo_cnt == TMO_LAST);
`else
  assign tmo_hit = 1'b0;
`endif

  assign abort = do_clear || tmo_hit;

  function automatic logic [19:0] render_op(input logic [6:0] v);
    logic [6:0] tens, ones;
    tens = v / 7'd10;
    ones = v % 7'd10;
    render_op = {BLANK, BLANK, (tens != 7'd0) ? 5'(tens) : BLANK, 5'(ones)};
  endfunction

  // Blank leading zeros and place the sign just left of the most significant digit.
  function automatic logic [19:0] render_res(input logic [3:0][3:0] b, input logic n);
    logic [4:0] d3, d2, d1, d0;
    d0 = {1'b0, b[0]};
    d1 = ((b[3] | b[2] | b[1]) != 4'd0) ? {1'b0, b[1]} : BLANK;
    d2 = ((b[3] | b[2]) != 4'd0) ? {1'b0, b[2]} : BLANK;
    d3 = (b[3] != 4'd0) ? {1'b0, b[3]} : BLANK;
    if (n) begin
      if (b[2] != 4'd0)      d3 = MINUS;
      else if (b[1] != 4'd0) d2 = MINUS;
      else                   d1 = MINUS;
    end
    render_res = {d3, d2, d1, d0};
  endfunction

  function automatic logic [14:0] weight(input logic [1:0] i);
    case (i)
      2'd3:    weight = 15'd1000;
      2'd2:    weight = 15'd100;
      default: weight = 15'd10;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      op_a       <= '0;
      op_b       <= '0;
      op_code    <= '0;
      cnt_a      <= '0;
      cnt_b      <= '0;
      calc_start <= 1'b0;
      mag        <= '0;
      neg        <= 1'b0;
      range_err  <= 1'b0;
      bcd        <= '0;
      k          <= 2'd3;
      {disp3, disp2, disp1, disp0} <= {4{BLANK}};
    end else begin
      calc_start <= 1'b0;
      if (abort) begin
        state   <= IDLE;
        op_a    <= '0;
        op_b    <= '0;
        op_code <= '0;
        cnt_a   <= '0;
        cnt_b   <= '0;
      end else begin
        case (state)
          IDLE, SHOW, ERR: if (rx_done && is_dig) begin
            op_a  <= dval;
            cnt_a <= 4'd1;
            state <= OPA;
          end
          OPA: if (rx_done) begin
            if (is_dig) begin
              if (cnt_a < NDIG_C) begin
                op_a  <= op_a * 7'd10 + dval;
                cnt_a <= cnt_a + 4'd1;
              end else state <= ERR;
            end else if (is_op) begin
              op_code <= opc;
              op_b    <= '0;
              cnt_b   <= '0;
              state   <= OPB;
            end
          end
          OPB: if (rx_done) begin
            if (is_dig) begin
              if (cnt_b < NDIG_C) begin
                op_b  <= op_b * 7'd10 + dval;
                cnt_b <= cnt_b + 4'd1;
              end else state <= ERR;
            end else if (is_op) state <= ERR;
            else if (is_eq && (cnt_b != 4'd0)) begin
              calc_start <= 1'b1;
              state      <= EXEC;
            end
          end
          EXEC: state <= WAIT;
          WAIT: if (calc_done) begin
            neg       <= calc_result[14];
            mag       <= calc_result[14] ? 15'(-calc_result) : calc_result;
            range_err <= ($signed(calc_result) > 15'sd9999) || ($signed(calc_result) < -15'sd999);
            bcd       <= '0;
            k         <= 2'd3;
            state     <= CONV;
          end
          // One subtraction or one digit advance per cycle; the remainder is the ones digit.
          CONV: begin
            if (range_err) state <= ERR;
            else if (mag >= weight(k)) begin
              mag    <= mag - weight(k);
              bcd[k] <= bcd[k] + 4'd1;
            end else if (k == 2'd1) begin
              bcd[0] <= mag[3:0];
              state  <= SHOW;
            end else k <= k - 2'd1;
          end
          default: state <= IDLE;
        endcase
      end

      // Display follows the already-registered state, giving one cycle of lag.
      case (state)
        IDLE:    {disp3, disp2, disp1, disp0} <= {4{BLANK}};
        OPA:     {disp3, disp2, disp1, disp0} <= render_op(op_a);
        OPB:     {disp3, disp2, disp1, disp0} <= render_op(op_b);
        SHOW:    {disp3, disp2, disp1, disp0} <= render_res(bcd, neg);
        ERR:     {disp3, disp2, disp1, disp0} <= {BLANK, BLANK, BLANK, ELET};
        default: ;
      endcase
    end
  end

endmodule
